dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
Arbitrates the single-port data memory between the pipeline M-stage (CPU port) and a DMA port. Sits between the M-stage/DMA engine and the DM macro, which has a synchronous word write at posedge and a combinational read. The CPU normally has priority. A starvation counter guarantees DMA progress. DMA transfers are uninterruptible bursts of up to 16 word beats, with the address incrementing inside the arbiter.

Parameters:
STARVE_LIMIT, 4, consecutive denied DMA-request cycles after which DMA wins over CPU
ADDR_LIMIT, 32'h0000_2FFC, highest legal word byte-address; burst address wraps from here to 0
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  M-stage access request this cycle
cpu_we  in  1  1=write, 0=read
cpu_addr  in  32  byte address
cpu_wd  in  32  write data
cpu_pc  in  32  PC of the M-stage instruction, forwarded for the write trace
cpu_rd  out  32  read data; 0 when the CPU is not served
cpu_stall  out  1  cpu_req high but not served this cycle
dma_req  in  1  burst request; held until dma_gnt
dma_we  in  1  burst direction, sampled at grant
dma_addr  in  32  burst base byte address, sampled at grant
dma_len  in  4  beats minus 1, sampled at grant
dma_wd  in  32  write data for the current beat
dma_gnt  out  1  one-cycle pulse on the cycle beat 0 issues
dma_beat  out  1  a DMA beat is issued this cycle
dma_rd  out  32  read data for the current beat; 0 otherwise
dma_done  out  1  pulse on the last beat
dm_we  out  1  DM write enable
dm_re  out  1  DM read enable
dm_addr  out  32  DM byte address, with bits [1:0] forced to 0
dm_wd  out  32  DM write data
dm_pc  out  32  cpu_pc on CPU accesses, 32'h0 on DMA accesses
dm_rd  in  32  DM read data

Behaviour:
- Reset sets state to IDLE and clears the starvation counter, beat counter, burst address and burst direction. While reset is high, all outputs are 0 (cpu_stall follows cpu_req).
- States:
  - IDLE: no burst in progress.
  - BURST: beats 1..len are being issued.
- IDLE decision, evaluated combinationally each cycle:
  - DMA wins if dma_req && (!cpu_req || starve_cnt == STARVE_LIMIT).
  - Otherwise the CPU wins if cpu_req.
- CPU win in IDLE:
  - dm_* is driven from cpu_*; dm_re = !cpu_we; dm_we = cpu_we; cpu_rd = dm_rd; cpu_stall = 0.
  - Zero-cycle latency.
  - If dma_req is also high, starve_cnt increments, saturating at STARVE_LIMIT.
- DMA win in IDLE:
  - dma_gnt = 1 and dma_beat = 1. Beat 0 uses dma_addr/dma_we/dma_wd directly.
  - starve_cnt clears to 0.
  - On the clock edge, the arbiter latches we, next address and remaining = dma_len.
  - If dma_len == 0, dma_done = 1 and the state stays IDLE. Otherwise the next state is BURST.
  - If cpu_req is high, cpu_stall = 1.
- BURST:
  - Each cycle issues one beat at the latched address with the latched we; dm_wd = dma_wd; dma_rd = dm_rd.
  - cpu_stall = cpu_req for the whole burst.
  - dma_req is ignored and starve_cnt holds.
  - On the edge, address advances by 4 and remaining decrements.
  - The beat issued with remaining == 1 is the last beat: dma_done = 1 and the next state is IDLE.
  - A burst of N beats therefore occupies exactly N consecutive cycles.
- Address wrap: the next address is 0 when the current address is ≥ ADDR_LIMIT; otherwise it is the current address + 4. Beat-0 dma_addr is passed through with [1:0] masked.
- No request: dm_we = dm_re = 0, dm_addr = dm_wd = dm_pc = 0, and both rd outputs are 0.
- Reset mid-burst: next cycle is IDLE with no dma_done. The DMA engine must re-request.
- Simultaneous dma_req and cpu_req with the counter at limit: DMA is granted and the CPU stalls for all N beats.
- Invariants:
  - dm_we and dm_re are never both 1.
  - At most one port is served per cycle.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state encoding (IDLE = 1'b0, BURST = 1'b1)
  - WORD_BYTES = 4
  - ADDR_LIMIT default
- Sub-module dm_arb_starve_cnt: saturating counter with inc/clr/at_limit.
- All else stays in dm_arbiter.

Test Plan:
1. CPU-only write: cpu_req=1, we=1, addr=0x10, wd=0xDEADBEEF, pc=0x3000 → same cycle dm_we=1, dm_addr=0x10, dm_pc=0x3000, cpu_stall=0; a later read of 0x10 returns cpu_rd=0xDEADBEEF.
2. DMA read burst: cpu_req=0, dma_req=1, addr=0x100, len=3 → 4 consecutive beats at 0x100/104/108/10C; dma_gnt on beat 0; dma_done on beat 3; 5th cycle dm_re=0.
3. Starvation: cpu_req held 1, dma_req=1, STARVE_LIMIT=4 → CPU served 4 cycles, counter saturates at 4; cycle 5 dma_gnt=1, cpu_stall=1; counter reads 0 after grant.
4. Wrap: dma_addr=0x2FF8, len=3, write → beat addresses 0x2FF8, 0x2FFC, 0x0000, 0x0004.
5. Reset mid-burst: len=7, assert reset at beat 3 → next cycle state IDLE, no dma_done, all outputs 0; a CPU request after reset is served immediately.
6. CPU during burst: len=1 granted, cpu_req=1 throughout → cpu_stall=1 for exactly 2 cycles, then CPU served with cpu_stall=0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, word size,
// address limits and the burst address-advance helper.
package dm_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic [31:0] WORD_BYTES     = 32'd4;
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_2FFC;
  localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

  // Next word address of a burst; wraps to 0 once the legal top is reached.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr,
                                                 input logic [31:0] limit);
    return (addr >= limit) ? '0 : addr + WORD_BYTES;
  endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating counter of consecutive cycles in which a DMA request lost to the CPU.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  assign at_limit = (cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the M-stage CPU port and a bursting
// DMA port; CPU has priority unless DMA has been starved STARVE_LIMIT cycles.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] ADDR_LIMIT   = ADDR_LIMIT_DEF,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_beat,
  output logic [31:0] dma_rd,
  output logic        dma_done,
  output logic        dm_we,
  output logic        dm_re,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  arb_state_t       state, state_next;
  logic [31:0]      burst_addr;
  logic             burst_we;
  logic [3:0]       remaining;
  logic             starve_inc, starve_clr, starve_at_limit;
  logic [CNT_W-1:0] starve_cnt;
  logic             dma_wins;

  dm_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

  assign dma_wins = dma_req && (!cpu_req || starve_at_limit);

  // Outputs stay gated to zero while reset is high; stall simply mirrors cpu_req.
  always_comb begin
    state_next = state;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    cpu_rd     = '0;
    cpu_stall  = cpu_req;
    dma_gnt    = 1'b0;
    dma_beat   = 1'b0;
    dma_rd     = '0;
    dma_done   = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    dm_addr    = '0;
    dm_wd      = '0;
    dm_pc      = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (dma_wins) begin
            dma_gnt    = 1'b1;
            dma_beat   = 1'b1;
            starve_clr = 1'b1;
            dm_addr    = dma_addr & WORD_MASK;
            dm_we      = dma_we;
            dm_re      = !dma_we;
            dm_wd      = dma_wd;
            dma_rd     = dm_rd;
            if (dma_len == 4'd0) begin
              dma_done = 1'b1;
            end else begin
              state_next = BURST;
            end
          end else if (cpu_req) begin
            cpu_stall  = 1'b0;
            starve_inc = dma_req;
            dm_addr    = cpu_addr & WORD_MASK;
            dm_we      = cpu_we;
            dm_re      = !cpu_we;
            dm_wd      = cpu_wd;
            dm_pc      = cpu_pc;
            cpu_rd     = dm_rd;
          end
        end
        BURST: begin
          dma_beat = 1'b1;
          dm_addr  = burst_addr;
          dm_we    = burst_we;
          dm_re    = !burst_we;
          dm_wd    = dma_wd;
          dma_rd   = dm_rd;
          if (remaining == 4'd1) begin
            dma_done   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_addr <= '0;
      burst_we   <= 1'b0;
      remaining  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && dma_wins) begin
        burst_we   <= dma_we;
        burst_addr <= next_word_addr(dma_addr & WORD_MASK, ADDR_LIMIT);
        remaining  <= dma_len;
      end else if (state == BURST) begin
        burst_addr <= next_word_addr(burst_addr, ADDR_LIMIT);
        remaining  <= remaining - 1'b1;
      end
    end
  end

endmodule
